conv3x3_mac_pipe: RTL
=====================

# conv3x3_mac_pipe

Parametrised 3x3 multi-channel convolution engine: the pipelined, flow-controlled successor of the fixed RGB888 3x3 convolver. It sits between the line-buffer window generator and the output pixel stream. It applies one 3x3 kernel (preset or AXI-supplied) to CH channels in parallel, then adds bias, rounds, shifts and clamps. Kernel/mode/shift/bias settings are frame-coherent via a shadow register loaded on start-of-frame. A per-frame saturation counter is maintained.

## Interface
- CH, 3: channel count per pixel
- DW, 8: bits per channel (unsigned)
- KW, 8: coefficient width (signed)
- ACCW, DW+KW+5: accumulator width (signed)
- iClk  in  1  clock
- iRst_n  in  1  reset; synchronous, active-low; clock iClk
- i_valid  in  1  input window valid
- o_ready  out  1  engine can accept a beat
- i_sof  in  1  first window of frame, qualified by i_valid
- i_win  in  9*CH*DW  window; pixel n (0..8, row-major, top-left first) at [n*CH*DW +: CH*DW]; channel c at [c*DW +: DW]; channel CH-1 most significant
- i_mode  in  2  00 sharpen, 01 strong sharpen, 10 identity, 11 custom
- i_kernel  in  9*KW  custom coefficient n at [n*KW +: KW], signed
- i_shift  in  4  right-shift amount 0..15
- i_bias  in  ACCW  signed bias added to every channel sum
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_pix  out  CH*DW  result, same channel packing as input
- o_sof  out  1  output beat is first of frame
- o_sat_cnt  out  16  clamped beats in current output frame

## Operation
- Acceptance: beat accepted when i_valid && o_ready. Output transfer: o_valid && i_ready.
- Shadow config {mode, kernel, shift, bias}. Reset value: mode 10, shift 0, bias 0. Loaded from the live inputs when an accepted beat has i_sof=1.
- The sof beat itself uses the live inputs. All other beats use the shadow. Live-input changes mid-frame have no effect until the next sof.
- Presets:
  - sharpen: 0,-1,0 / -1,5,-1 / 0,-1,0
  - strong sharpen: -1×8 with centre 9
  - identity: centre 1, others 0
  - custom: i_kernel
- Per channel: sum = Σ zero-extended pixel × signed coeff + bias, computed in ACCW bits.
- Rounding: if shift>0, add 1<<(shift-1). Then arithmetic right shift by shift.
- Clamp to [0, 2^DW-1]. Beat is "clamped" if any channel hit either bound.
- o_sat_cnt updates on output transfer:
  - if o_sof: becomes 1 if the beat was clamped, else 0
  - else: increments when clamped, saturating at 16'hFFFF
- Reset (any time, including mid-frame): pipeline valids cleared, in-flight beats discarded, shadow back to reset values.

## Timing
- 3 register stages:
  - S1: channel products, config and sof registered
  - S2: adder tree + bias
  - S3: round/shift/clamp; o_pix, o_sof, o_valid
- Latency: 3 cycles from acceptance to o_valid with i_ready held high. Throughput 1 beat/cycle.
- Global stall: o_ready = !(o_valid && !i_ready), combinational. While stalled, all stages hold and o_pix/o_sof/o_valid are stable.
- Bubbles are not squeezed out: stalling only occurs when S3 holds valid data.
- Reset values: o_valid 0, o_pix 0, o_sof 0, o_sat_cnt 0. o_ready is 1 the cycle after reset is released.
- Simultaneous sof acceptance and o_sof transfer: these are independent. The shadow load affects the new beat; the counter clear affects the output side.

## Test plan
- Identity mode, sof beat, window with centre {10,20,30}, one beat -> o_pix {10,20,30} exactly 3 cycles after acceptance; o_sat_cnt 0.
- Sharpen, centre channel 200, cross neighbours 100, corners 0 -> 600 clamps to 255 on every channel; o_sat_cnt 1. Strong sharpen, centre 0, neighbours 50 -> 0; o_sat_cnt 2.
- Custom all-ones kernel, shift 3, bias 0, uniform windows 80 / 3 / 1 -> 90 / 3 / 1 (round-half-up check). Bias -720 with uniform 80 -> 0, not clamped.
- Frame with sof under mode 10, then live i_mode switched to 00 mid-frame -> remaining beats stay identity. Next sof beat uses sharpen.
- i_ready low for 5 cycles during a 10-beat burst -> o_ready low while S3 is valid, no loss or duplication, o_pix stable, order preserved.
- iRst_n low for 1 cycle with 3 beats in flight -> o_valid 0 next cycle, no stale beats emerge, shadow back to identity, o_sat_cnt 0.

Source files
------------

// File: rtl/conv3x3_mac_pipe.sv
// rtl/conv3x3_mac_pipe.sv - 3-stage CH-channel 3x3 convolution MAC with frame-coherent config
module conv3x3_mac_pipe #(
   parameter int CH   = 3,
   parameter int DW   = 8,
   parameter int KW   = 8,
   parameter int ACCW = DW + KW + 5
) (
   input  logic                   iClk,
   input  logic                   iRst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic                   i_sof,
   input  logic [9*CH*DW-1:0]     i_win,
   input  logic [1:0]             i_mode,
   input  logic [9*KW-1:0]        i_kernel,
   input  logic [3:0]             i_shift,
   input  logic signed [ACCW-1:0] i_bias,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [CH*DW-1:0]       o_pix,
   output logic                   o_sof,
   output logic [15:0]            o_sat_cnt
);
   localparam int PW = DW + KW + 1;
   localparam logic signed [ACCW-1:0] PIX_MAX = ACCW'((1 << DW) - 1);

   logic                   adv, take;
   logic [1:0]             sh_mode, eff_mode;
   logic [9*KW-1:0]        sh_kernel, eff_kernel, coef;
   logic [3:0]             sh_shift, eff_shift;
   logic signed [ACCW-1:0] sh_bias, eff_bias;

   logic                   s1_valid, s1_sof, s2_valid, s2_sof, o_clamp;
   logic [3:0]             s1_shift, s2_shift;
   logic signed [ACCW-1:0] s1_bias;
   logic signed [PW-1:0]   s1_prod [CH][9];
   logic signed [ACCW-1:0] sum_c [CH];
   logic signed [ACCW-1:0] s2_sum [CH];
   logic signed [ACCW-1:0] rnd_c [CH];
   logic signed [ACCW-1:0] shd_c [CH];
   logic [CH*DW-1:0]       pix_c;
   logic                   clamp_c;

   function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] p, input logic [KW-1:0] k);
      logic signed [PW-1:0] pe, ke;
      pe = $signed({{(PW-DW){1'b0}}, p});
      ke = $signed({{(PW-KW){k[KW-1]}}, k});
      return pe * ke;
   endfunction

   // Whole pipeline stalls only when the output register holds an unaccepted beat
   assign o_ready = !(o_valid && !i_ready);
   assign adv     = o_ready;
   assign take    = i_valid && o_ready;

   // The sof beat bypasses the shadow so it already runs under the new frame's config
   always_comb begin
      if (i_sof) begin
         eff_mode   = i_mode;
         eff_kernel = i_kernel;
         eff_shift  = i_shift;
         eff_bias   = i_bias;
      end else begin
         eff_mode   = sh_mode;
         eff_kernel = sh_kernel;
         eff_shift  = sh_shift;
         eff_bias   = sh_bias;
      end
   end

   always_comb begin
      coef = '0;
      for (int n = 0; n < 9; n++) begin
         case (eff_mode)
            2'b00:   coef[n*KW +: KW] = (n == 4) ? KW'(5) : ((n % 2 == 1) ? {KW{1'b1}} : KW'(0));
            2'b01:   coef[n*KW +: KW] = (n == 4) ? KW'(9) : {KW{1'b1}};
            2'b10:   coef[n*KW +: KW] = (n == 4) ? KW'(1) : KW'(0);
            default: coef[n*KW +: KW] = eff_kernel[n*KW +: KW];
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         sh_mode   <= 2'b10;
         sh_kernel <= '0;
         sh_shift  <= '0;
         sh_bias   <= '0;
      end else if (take && i_sof) begin
         sh_mode   <= i_mode;
         sh_kernel <= i_kernel;
         sh_shift  <= i_shift;
         sh_bias   <= i_bias;
      end
   end

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         sum_c[c] = s1_bias;
         for (int n = 0; n < 9; n++)
            sum_c[c] = sum_c[c] + {{(ACCW-PW){s1_prod[c][n][PW-1]}}, s1_prod[c][n]};
      end
   end

   // Round half up, arithmetic shift, then clamp; exact 0 or max is in range, not clamped
   always_comb begin
      pix_c   = '0;
      clamp_c = 1'b0;
      for (int c = 0; c < CH; c++) begin
         rnd_c[c] = s2_sum[c];
         if (s2_shift != 4'd0)
            rnd_c[c] = rnd_c[c] + (ACCW'(1) << (s2_shift - 4'd1));
         shd_c[c] = rnd_c[c] >>> s2_shift;
         if (shd_c[c][ACCW-1]) begin
            clamp_c = 1'b1;
         end else if (shd_c[c] > PIX_MAX) begin
            pix_c[c*DW +: DW] = '1;
            clamp_c           = 1'b1;
         end else begin
            pix_c[c*DW +: DW] = shd_c[c][DW-1:0];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_shift <= '0;
         s1_bias  <= '0;
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_shift <= '0;
         o_valid  <= 1'b0;
         o_sof    <= 1'b0;
         o_pix    <= '0;
         o_clamp  <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            s2_sum[c] <= '0;
            for (int n = 0; n < 9; n++) s1_prod[c][n] <= '0;
         end
      end else if (adv) begin
         s1_valid <= i_valid;
         s1_sof   <= i_valid && i_sof;
         s1_shift <= eff_shift;
         s1_bias  <= eff_bias;
         for (int c = 0; c < CH; c++)
            for (int n = 0; n < 9; n++)
               s1_prod[c][n] <= mul(i_win[(n*CH + c)*DW +: DW], coef[n*KW +: KW]);
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_shift <= s1_shift;
         for (int c = 0; c < CH; c++) s2_sum[c] <= sum_c[c];
         o_valid  <= s2_valid;
         o_sof    <= s2_sof;
         o_pix    <= pix_c;
         o_clamp  <= clamp_c;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         o_sat_cnt <= '0;
      end else if (o_valid && i_ready) begin
         if (o_sof)
            o_sat_cnt <= {15'd0, o_clamp};
         else if (o_clamp && o_sat_cnt != 16'hFFFF)
            o_sat_cnt <= o_sat_cnt + 16'd1;
      end
   end
endmodule
